// File: rtl/hydrophone_ping_gen.sv
// hydrophone_ping_gen: periodic square-wave pinger bursts with per-channel delay; HYDROPHONE_PING_POLARITY_EN adds ch_invert
module hydrophone_ping_gen #(
    parameter int NUM_CH  = 4,
    parameter int TIME_W  = 24,
    parameter int DELAY_W = 16,
    parameter int DIV_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [DIV_W-1:0]           tone_half,
    input  logic [TIME_W-1:0]          ping_len,
    input  logic [TIME_W-1:0]          ping_period,
    input  logic [NUM_CH*DELAY_W-1:0]  ch_delay,
`ifdef HYDROPHONE_PING_POLARITY_EN
    input  logic [NUM_CH-1:0]          ch_invert,
`endif
    output logic [NUM_CH-1:0]          sig_out,
    output logic                       ping_start,
    output logic                       busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                      state;
    logic [TIME_W-1:0]           cnt, sh_len, sh_period;
    logic [DIV_W-1:0]            sh_half, h_eff;
    logic [NUM_CH*DELAY_W-1:0]   sh_delay;
    logic [NUM_CH-1:0]           sh_inv, inv_in, ph, ph_nxt, tone_nxt;
    logic [NUM_CH*DIV_W-1:0]     hc, hc_nxt;
    logic                        wrap, load, run_nxt;
`ifdef HYDROPHONE_PING_POLARITY_EN
    assign inv_in = ch_invert;
`else
    assign inv_in = '0;
`endif
    assign h_eff   = (sh_half == '0) ? DIV_W'(1) : sh_half;
    assign wrap    = cnt == sh_period - 1'b1;
    assign load    = enable && ping_period != '0 && (state == IDLE || wrap);
    assign run_nxt = load || (state == RUN && enable && !wrap);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DELAY_W-1:0] d;
        logic [TIME_W:0]    win_end;
        logic [DIV_W-1:0]   hc_cur;
        logic               start, active, roll, ph_cur;
        assign d       = sh_delay[i*DELAY_W +: DELAY_W];
        assign win_end = (TIME_W+1)'(d) + (TIME_W+1)'(sh_len);
        assign start   = {1'b0, cnt} == (TIME_W+1)'(d);
        assign active  = {1'b0, cnt} >= (TIME_W+1)'(d) && {1'b0, cnt} < win_end;
        // the phase restarts at the window start so a burst always begins high
        assign hc_cur  = start ? '0 : hc[i*DIV_W +: DIV_W];
        assign ph_cur  = start ? 1'b0 : ph[i];
        assign roll    = hc_cur == h_eff - 1'b1;
        assign tone_nxt[i] = active & (~ph_cur ^ sh_inv[i]);
        assign ph_nxt[i]   = ph_cur ^ roll;
        assign hc_nxt[i*DIV_W +: DIV_W] = roll ? '0 : hc_cur + 1'b1;
    end
    // FSM, period counter, shadow latch, tone phase and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sh_half    <= '0;
            sh_len     <= '0;
            sh_period  <= '0;
            sh_delay   <= '0;
            sh_inv     <= '0;
            hc         <= '0;
            ph         <= '0;
            sig_out    <= '0;
            ping_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= run_nxt ? RUN : IDLE;
            busy       <= run_nxt;
            ping_start <= load;
            cnt        <= (run_nxt && !load) ? cnt + 1'b1 : '0;
            sig_out    <= (state == RUN && run_nxt) ? tone_nxt : '0;
            hc         <= hc_nxt;
            ph         <= ph_nxt;
            if (load) begin
                sh_half   <= tone_half;
                sh_len    <= ping_len;
                sh_period <= ping_period;
                sh_delay  <= ch_delay;
                sh_inv    <= inv_in;
            end
        end
    end
endmodule
